// File: rtl/bla_pkg.sv
// Shared types and helpers for the sequential borrow-lookahead subtractor.
// Holds the FSM state enum, the slice width and the slice-counter width function.
package bla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must index n slices (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bla_sub_seq_if.sv
// Operand/result handshake bundle for bla_sub_seq; ovf exists only when
// BLA_SUB_OVF_EN is defined.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds its payload stable while valid is high and ready is low.
interface bla_sub_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef BLA_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef BLA_SUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef BLA_SUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/bla4.sv
// Purely combinational 4-bit borrow-lookahead slice computing x - y - bi.
// Every borrow is a flat sum of products of generate/propagate terms.
module bla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] bw;

  // g: this bit borrows on its own; p: an incoming borrow passes straight through.
  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign bw[0] = bi;
  assign bw[1] = g[0] | (p[0] & bi);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bi);
  assign bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d  = x ^ y ^ bw[3:0];
  assign bo = bw[4];

endmodule

// File: rtl/bla_sub_seq.sv
// Multi-cycle a - b - bin subtractor: one bla4 slice reused per clock, LSB nibble first.
// Define BLA_SUB_OVF_EN to add the signed-overflow output.
module bla_sub_seq
  import bla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  bla_sub_seq_if.slave bus,
  output state_t       dbg_state
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int KW = cnt_w(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t           state_q;
  state_t           state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bw_q;

  logic [SLICE_W-1:0] slice_x;
  logic [SLICE_W-1:0] slice_y;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bo;

  assign slice_x = a_q[SLICE_W*k_q +: SLICE_W];
  assign slice_y = b_q[SLICE_W*k_q +: SLICE_W];

  bla4 u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .bi (bw_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)     state_d = RUN;
      RUN:     if (k_q == K_LAST)    state_d = DONE;
      DONE:    if (bus.out_ready)    state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Datapath: operands and borrow captured on accept, one nibble retired per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bw_q   <= 1'b0;
      k_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            bw_q   <= bus.bin;
            diff_q <= '0;
            k_q    <= '0;
          end
        end
        RUN: begin
          diff_q[SLICE_W*k_q +: SLICE_W] <= slice_d;
          bw_q                           <= slice_bo;
          if (k_q != K_LAST) k_q <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Both handshake flags are plain state decodes, so they can never be high together.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bw_q;
  assign dbg_state     = state_q;

`ifdef BLA_SUB_OVF_EN
  assign bus.ovf = (state_q == DONE) & (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                 & (diff_q[WIDTH-1] ^ a_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_bla_sub_seq.sv
// Directed bench for bla_sub_seq (WIDTH=16): hand-computed vectors, latency,
// backpressure and mid-operation reset; ovf checked when BLA_SUB_OVF_EN is defined.
module tb_bla_sub_seq;
  import bla_pkg::*;

  localparam int W = 16;
  localparam int N = W / 4;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  bla_sub_seq_if #(.WIDTH(W)) bus ();

  bla_sub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation; hold > 0 keeps out_ready low for that many cycles once the result is up.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic [W-1:0] ed, input logic eb,
                       input logic eo, input int hold);
    logic [W:0] exp;
    logic [W-1:0] held_diff;
    int t;
    int lat;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    exp_q.push_back({eb, ed});
    bus.out_ready = (hold == 0);
    bus.a         = a;
    bus.b         = b;
    bus.bin       = bin;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom_range(0, 65535));
    bus.b        = W'($urandom_range(0, 65535));
    bus.bin      = 1'($urandom_range(0, 1));
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N));
    exp = exp_q.pop_front();
    chk({tag, "_diff"}, 32'(bus.diff), 32'(exp[W-1:0]));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(exp[W]));
`ifdef BLA_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", tag);
`endif
    chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    if (hold > 0) begin
      held_diff = bus.diff;
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.a        = W'($urandom_range(0, 65535));
        bus.b        = W'($urandom_range(0, 65535));
        @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_hold_diff"}, 32'(bus.diff), 32'(held_diff));
        chk({tag, "_hold_bout"}, 32'(bus.bout), 32'(exp[W]));
        chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef BLA_SUB_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    do_op("basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
    do_op("chain",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op("bin_zero", 16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 0);
    do_op("bin_wrap", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op("ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
    do_op("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
    do_op("mixed",    16'h1234, 16'h5678, 1'b0, 16'hBBBC, 1'b1, 1'b0, 0);
    do_op("alt",      16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 0);
    do_op("backpr",   16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 6);

    // Abort after two RUN edges of FFFF - 1111 (low two nibbles already 0xEE).
    bus.a        = 16'hFFFF;
    bus.b        = 16'h1111;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_partial", 32'(bus.diff), 32'h00EE);
    rst = 1'b1;
    #1;
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op("post_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bla_sub_seq.md
# bla_sub_seq

Iterative WIDTH-bit subtractor that computes `a - b - bin` one 4-bit borrow-lookahead slice per clock. It is the subtraction counterpart of the team's 4-bit carry-lookahead adder. It sits behind a valid/ready input handshake and a valid/ready output handshake, so arithmetic datapaths can share it as a multi-cycle functional unit. One combinational 4-bit borrow-lookahead slice is reused every cycle; inter-slice borrow is held in a register.

## Interface
- `WIDTH`, 16: operand width in bits; must be a multiple of 4 and at least 4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `bin` in 1: borrow in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `diff` out WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout` out 1: borrow out; 1 iff `a < b + bin` (unsigned).
- `ovf` out 1: signed overflow; present only with `BLA_SUB_OVF_EN`.

## Operation
- Definitions: `N = WIDTH/4`; slice index `k` runs from 0 to N-1, LSB nibble first.
- State machine:
  - IDLE: `in_ready=1`. On `in_valid&&in_ready`, latch `a`, `b`; set borrow register to `bin`, `k=0`, clear `diff`; go to RUN.
  - RUN: each cycle the slice computes nibble k from `a[4k+3:4k]`, `b[4k+3:4k]` and the borrow register. Write that nibble into `diff[4k+3:4k]`, load the borrow register with the slice's borrow out, then `k++`. When `k==N-1`, go to DONE instead.
  - DONE: `out_valid=1`; `diff`, `bout`, `ovf` stable. On `out_ready`, go to IDLE.
- Slice equations:
  - `g = ~x & y`, `p = ~(x ^ y)`, `bw0 = bi`
  - `bw[i+1] = g[i] | p[i]&bw[i]`, fully expanded (lookahead, not ripple)
  - `d = x ^ y ^ bw[3:0]`, `bo = bw[4]`
- `bout` is the final borrow register value.
- `ovf = (a[W-1]^b[W-1]) & (diff[W-1]^a[W-1])`, using the latched operands.
- Operand inputs are ignored outside the accepting edge. `in_valid` during RUN or DONE is not accepted (`in_ready=0`).
- `in_ready` and `out_valid` are never high together.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`, `k=0`, borrow register 0.
- Reset asserted in any state, including mid-RUN, aborts the operation immediately. The partial result is discarded; the first acceptable edge is the first rising edge after deassertion.
- Latency: if operands are accepted at edge E, `out_valid` rises after edge E+N (4 cycles for WIDTH=16).
- Output hold: `out_valid` and result stay held until `out_ready`; there is no timeout.
- Throughput: with `out_ready` tied high, one result every N+2 cycles. Per operation: accept edge, N RUN edges, one DONE→IDLE edge, then the next accept.
- `in_ready` is a registered state decode, not combinational from `out_ready`. The next operation cannot be accepted on the same edge as the result handshake.
- WIDTH=4: RUN lasts exactly one cycle.

## Configuration
- `BLA_SUB_OVF_EN` defined: `ovf` port and logic present, valid while `out_valid=1`, 0 otherwise.
- `BLA_SUB_OVF_EN` undefined: `ovf` port, MSB operand latch usage and overflow logic omitted. All other behaviour is identical.

## Structure
- Package `bla_pkg` holds:
  - state enum (IDLE, RUN, DONE)
  - `SLICE_W = 4`
  - the function computing counter width from `WIDTH/SLICE_W`
- Sub-module `bla4`: purely combinational 4-bit borrow-lookahead slice.
  - Ports: `x[3:0]`, `y[3:0]`, `bi` → `d[3:0]`, `bo`.
  - The top instantiates it once.

## Test plan
- Basic: `a=0x1234`, `b=0x0234`, `bin=0` → `diff=0x1000`, `bout=0`, `out_valid` exactly 4 cycles after accept.
- Full borrow chain: `0x0000 - 0x0001`, `bin=0` → `diff=0xFFFF`, `bout=1`, `ovf=0`.
- Borrow in: `0x0010 - 0x000F`, `bin=1` → `diff=0x0000`, `bout=0`. `0x0000 - 0x0000`, `bin=1` → `0xFFFF`, `bout=1`.
- Overflow (macro on): `0x8000 - 0x0001` → `diff=0x7FFF`, `bout=0`, `ovf=1`. `0x7FFF - 0xFFFF` → `0x8000`, `ovf=1`.
- Backpressure: hold `out_ready=0` for 6 cycles → `out_valid`, `diff`, `bout` stable, `in_ready=0`, new `in_valid` ignored. After `out_ready`, IDLE next cycle.
- Reset mid-RUN: assert `rst` after 2 RUN cycles of `0xFFFF - 0x1111` → outputs all 0 immediately, `in_ready=1`. A next op `0x0005 - 0x0003` yields `0x0002`.
